// File: rtl/rs_alu_param.sv
// rs_alu_param: parametrised ALU reservation station.
// Holds up to DEPTH renamed ALU ops and snoops NUM_CDB result buses to
// wake up their pending operands. It issues one ready op per cycle through
// a registered valid/ready output stage that supports backpressure.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rdy                 global enable; low holds every register
//   flush               synchronous squash of all entries and the output stage
//   alloc_*             decoder/rename allocation channel (valid/ready)
//   cdb_valid/tag/data  packed result broadcast channels, channel i at [i*W +: W]
//   issue_*             registered issue channel towards the ALU (valid/ready)
//   count               number of occupied entries
//
// Optional build macro RS_OLDEST_FIRST_EN: when it is defined, an age matrix
// makes issue pick the oldest ready entry. When it is undefined, issue picks
// the lowest-index ready entry.
module rs_alu_param #(
    parameter int DEPTH   = 8,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 4,
    parameter logic [TAG_W-1:0] TAG_FREE = '0,
    parameter int NUM_CDB = 2,
    parameter int OP_W    = 6,
    parameter int PC_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        flush,
    input  logic                        alloc_valid,
    output logic                        alloc_ready,
    input  logic [OP_W-1:0]             alloc_op,
    input  logic [PC_W-1:0]             alloc_pc,
    input  logic [DATA_W-1:0]           alloc_src1_data,
    input  logic [DATA_W-1:0]           alloc_src2_data,
    input  logic [TAG_W-1:0]            alloc_src1_tag,
    input  logic [TAG_W-1:0]            alloc_src2_tag,
    input  logic [TAG_W-1:0]            alloc_dest,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_data,
    output logic                        issue_valid,
    input  logic                        issue_ready,
    output logic [OP_W-1:0]             issue_op,
    output logic [PC_W-1:0]             issue_pc,
    output logic [DATA_W-1:0]           issue_src1,
    output logic [DATA_W-1:0]           issue_src2,
    output logic [TAG_W-1:0]            issue_dest,
    output logic [$clog2(DEPTH+1)-1:0]  count
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int IW = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [DEPTH-1:0]  busy_q;
    logic [OP_W-1:0]   op_q    [DEPTH];
    logic [PC_W-1:0]   pc_q    [DEPTH];
    logic [DATA_W-1:0] data1_q [DEPTH];
    logic [DATA_W-1:0] data2_q [DEPTH];
    logic [TAG_W-1:0]  tag1_q  [DEPTH];
    logic [TAG_W-1:0]  tag2_q  [DEPTH];
    logic [TAG_W-1:0]  dest_q  [DEPTH];
    logic [CW-1:0]     count_q;

    logic              issueValid_q;
    logic [OP_W-1:0]   issueOp_q;
    logic [PC_W-1:0]   issuePc_q;
    logic [DATA_W-1:0] issueSrc1_q;
    logic [DATA_W-1:0] issueSrc2_q;
    logic [TAG_W-1:0]  issueDest_q;

    logic [TAG_W-1:0]  fwdTag1  [DEPTH];
    logic [TAG_W-1:0]  fwdTag2  [DEPTH];
    logic [DATA_W-1:0] fwdData1 [DEPTH];
    logic [DATA_W-1:0] fwdData2 [DEPTH];
    logic [DEPTH-1:0]  readyVec;
    logic [TAG_W-1:0]  capTag1, capTag2;
    logic [DATA_W-1:0] capData1, capData2;
    logic [IW-1:0]     allocIdx, selIdx;
    logic              anyReady, issueLoad, issueFire, allocFire;

    assign alloc_ready = (count_q < DEPTH_C);
    assign allocFire   = rdy && alloc_valid && alloc_ready && !flush;
    assign issueLoad   = !issueValid_q || issue_ready;
    assign anyReady    = |readyVec;
    assign issueFire   = rdy && !flush && issueLoad && anyReady;

    assign issue_valid = issueValid_q;
    assign issue_op    = issueOp_q;
    assign issue_pc    = issuePc_q;
    assign issue_src1  = issueSrc1_q;
    assign issue_src2  = issueSrc2_q;
    assign issue_dest  = issueDest_q;
    assign count       = count_q;

    // Forwarded view of each entry: the CDB is applied on top of the stored
    // operands. Channels are scanned from high to low so the lowest matching
    // channel is the one that sticks. An entry whose forwarded tags are both
    // free is ready, so it can issue in its own wakeup cycle.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fwdTag1[i]  = tag1_q[i];
            fwdTag2[i]  = tag2_q[i];
            fwdData1[i] = data1_q[i];
            fwdData2[i] = data2_q[i];
            for (int c = NUM_CDB-1; c >= 0; c--) begin
                if (cdb_valid[c] && tag1_q[i] != TAG_FREE &&
                    cdb_tag[c*TAG_W +: TAG_W] == tag1_q[i]) begin
                    fwdTag1[i]  = TAG_FREE;
                    fwdData1[i] = cdb_data[c*DATA_W +: DATA_W];
                end
                if (cdb_valid[c] && tag2_q[i] != TAG_FREE &&
                    cdb_tag[c*TAG_W +: TAG_W] == tag2_q[i]) begin
                    fwdTag2[i]  = TAG_FREE;
                    fwdData2[i] = cdb_data[c*DATA_W +: DATA_W];
                end
            end
            readyVec[i] = busy_q[i] && fwdTag1[i] == TAG_FREE && fwdTag2[i] == TAG_FREE;
        end
    end

    // Incoming operands are also checked against this cycle's CDB, so a
    // result broadcast in the allocation cycle is not lost.
    always_comb begin
        capTag1  = alloc_src1_tag;
        capTag2  = alloc_src2_tag;
        capData1 = alloc_src1_data;
        capData2 = alloc_src2_data;
        for (int c = NUM_CDB-1; c >= 0; c--) begin
            if (cdb_valid[c] && alloc_src1_tag != TAG_FREE &&
                cdb_tag[c*TAG_W +: TAG_W] == alloc_src1_tag) begin
                capTag1  = TAG_FREE;
                capData1 = cdb_data[c*DATA_W +: DATA_W];
            end
            if (cdb_valid[c] && alloc_src2_tag != TAG_FREE &&
                cdb_tag[c*TAG_W +: TAG_W] == alloc_src2_tag) begin
                capTag2  = TAG_FREE;
                capData2 = cdb_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // The lowest free slot is taken from registered busy bits only. A slot
    // freed by this cycle's issue is not reused until the next cycle.
    always_comb begin
        allocIdx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (!busy_q[i]) allocIdx = IW'(i);
        end
    end

`ifdef RS_OLDEST_FIRST_EN
    // age_q[i][j] set means entry i was allocated before entry j. A new
    // entry is younger than every entry that stays busy. A freed entry has
    // its row and column cleared.
    logic [DEPTH-1:0] age_q [DEPTH];
    logic [DEPTH-1:0] age_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) age_d[i] = age_q[i];
        if (issueFire) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_d[selIdx][i] = 1'b0;
                age_d[i][selIdx] = 1'b0;
            end
        end
        if (allocFire) begin
            for (int i = 0; i < DEPTH; i++) begin
                age_d[allocIdx][i] = 1'b0;
                age_d[i][allocIdx] = busy_q[i] && !(issueFire && selIdx == IW'(i));
            end
        end
    end

    // The oldest ready entry is the one that no other ready entry is older than.
    always_comb begin
        logic blocked;
        blocked = 1'b0;
        selIdx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (readyVec[j] && age_q[j][i]) blocked = 1'b1;
            end
            if (readyVec[i] && !blocked) selIdx = IW'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
        end else if (rdy) begin
            for (int i = 0; i < DEPTH; i++) age_q[i] <= flush ? '0 : age_d[i];
        end
    end
`else
    // Fixed priority: the lowest-index ready entry issues.
    always_comb begin
        selIdx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (readyVec[i]) selIdx = IW'(i);
        end
    end
`endif

    // Entry storage, wakeup, the output register and the occupancy count.
    // Flush wins over everything else. When the output register cannot load,
    // it holds and no entry is freed, but wakeups still land in the entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= '0;
            count_q      <= '0;
            issueValid_q <= 1'b0;
            issueOp_q    <= '0;
            issuePc_q    <= '0;
            issueSrc1_q  <= '0;
            issueSrc2_q  <= '0;
            issueDest_q  <= TAG_FREE;
            for (int i = 0; i < DEPTH; i++) begin
                op_q[i]    <= '0;
                pc_q[i]    <= '0;
                data1_q[i] <= '0;
                data2_q[i] <= '0;
                tag1_q[i]  <= TAG_FREE;
                tag2_q[i]  <= TAG_FREE;
                dest_q[i]  <= TAG_FREE;
            end
        end else if (rdy) begin
            if (flush) begin
                busy_q       <= '0;
                count_q      <= '0;
                issueValid_q <= 1'b0;
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (busy_q[i]) begin
                        tag1_q[i]  <= fwdTag1[i];
                        tag2_q[i]  <= fwdTag2[i];
                        data1_q[i] <= fwdData1[i];
                        data2_q[i] <= fwdData2[i];
                    end
                end
                if (issueLoad) begin
                    issueValid_q <= anyReady;
                    if (anyReady) begin
                        issueOp_q        <= op_q[selIdx];
                        issuePc_q        <= pc_q[selIdx];
                        issueSrc1_q      <= fwdData1[selIdx];
                        issueSrc2_q      <= fwdData2[selIdx];
                        issueDest_q      <= dest_q[selIdx];
                        busy_q[selIdx]   <= 1'b0;
                    end
                end
                if (allocFire) begin
                    busy_q[allocIdx]  <= 1'b1;
                    op_q[allocIdx]    <= alloc_op;
                    pc_q[allocIdx]    <= alloc_pc;
                    dest_q[allocIdx]  <= alloc_dest;
                    tag1_q[allocIdx]  <= capTag1;
                    tag2_q[allocIdx]  <= capTag2;
                    data1_q[allocIdx] <= capData1;
                    data2_q[allocIdx] <= capData2;
                end
                count_q <= count_q + CW'(allocFire) - CW'(issueFire);
            end
        end
    end

endmodule

// File: tb/tb_rs_alu_param.sv
// tb_rs_alu_param: randomized and directed bench for rs_alu_param.
// A behavioural model holds the station as a list of entries with
// allocation sequence numbers. It is stepped on every rising clock edge,
// and one compare process checks the DUT against it. Directed scenarios
// add hand-computed literal expectations.
module tb_rs_alu_param;
    localparam int DEPTH = 8;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int NC    = 2;
    localparam int OW    = 6;
    localparam int PW    = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            rdy;
    logic            flush;
    logic            alloc_valid;
    logic            alloc_ready;
    logic [OW-1:0]   alloc_op;
    logic [PW-1:0]   alloc_pc;
    logic [DW-1:0]   alloc_src1_data, alloc_src2_data;
    logic [TW-1:0]   alloc_src1_tag, alloc_src2_tag, alloc_dest;
    logic [NC-1:0]   cdb_valid;
    logic [NC*TW-1:0] cdb_tag;
    logic [NC*DW-1:0] cdb_data;
    logic            issue_valid;
    logic            issue_ready;
    logic [OW-1:0]   issue_op;
    logic [PW-1:0]   issue_pc;
    logic [DW-1:0]   issue_src1, issue_src2;
    logic [TW-1:0]   issue_dest;
    logic [3:0]      count;

    int checks = 0;
    int errors = 0;

    rs_alu_param #(
        .DEPTH(DEPTH), .DATA_W(DW), .TAG_W(TW), .TAG_FREE(4'd0),
        .NUM_CDB(NC), .OP_W(OW), .PC_W(PW)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_op(alloc_op), .alloc_pc(alloc_pc),
        .alloc_src1_data(alloc_src1_data), .alloc_src2_data(alloc_src2_data),
        .alloc_src1_tag(alloc_src1_tag), .alloc_src2_tag(alloc_src2_tag),
        .alloc_dest(alloc_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_op(issue_op), .issue_pc(issue_pc),
        .issue_src1(issue_src1), .issue_src2(issue_src2),
        .issue_dest(issue_dest), .count(count)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    bit          mBusy [DEPTH];
    logic [5:0]  mOp   [DEPTH];
    logic [31:0] mPc   [DEPTH];
    logic [31:0] mD1   [DEPTH];
    logic [31:0] mD2   [DEPTH];
    logic [3:0]  mT1   [DEPTH];
    logic [3:0]  mT2   [DEPTH];
    logic [3:0]  mDest [DEPTH];
    int          mSeq  [DEPTH];
    int          mCnt;
    int          nextSeq;
    bit          mIv;
    logic [5:0]  mIOp;
    logic [31:0] mIPc, mISrc1, mISrc2;
    logic [3:0]  mIDest;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Lowest valid channel whose tag matches a pending tag supplies the data.
    function automatic bit cdbHit(input logic [3:0] t, output logic [31:0] d);
        d = '0;
        if (t == 4'd0) return 1'b0;
        for (int c = 0; c < NC; c++) begin
            if (cdb_valid[c] && cdb_tag[c*TW +: TW] == t) begin
                d = cdb_data[c*DW +: DW];
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) mBusy[i] = 1'b0;
        mCnt = 0;
        mIv = 1'b0;
        mIOp = '0; mIPc = '0; mISrc1 = '0; mISrc2 = '0; mIDest = '0;
        nextSeq = 0;
    endtask

    task automatic modelStep();
        logic [3:0]  wt1 [DEPTH];
        logic [3:0]  wt2 [DEPTH];
        logic [31:0] wd1 [DEPTH];
        logic [31:0] wd2 [DEPTH];
        logic [31:0] d;
        int ai, sel;
        if (rst) begin modelReset(); return; end
        if (!rdy) return;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) mBusy[i] = 1'b0;
            mCnt = 0;
            mIv = 1'b0;
            return;
        end
        for (int i = 0; i < DEPTH; i++) begin
            wt1[i] = mT1[i]; wd1[i] = mD1[i];
            wt2[i] = mT2[i]; wd2[i] = mD2[i];
            if (mBusy[i] && cdbHit(mT1[i], d)) begin wt1[i] = 4'd0; wd1[i] = d; end
            if (mBusy[i] && cdbHit(mT2[i], d)) begin wt2[i] = 4'd0; wd2[i] = d; end
        end
        ai = -1;
        if (alloc_valid && mCnt < DEPTH) begin
            for (int i = DEPTH-1; i >= 0; i--) if (!mBusy[i]) ai = i;
        end
        if (!mIv || issue_ready) begin
            sel = -1;
            for (int i = 0; i < DEPTH; i++) begin
                if (mBusy[i] && wt1[i] == 4'd0 && wt2[i] == 4'd0) begin
`ifdef RS_OLDEST_FIRST_EN
                    if (sel < 0 || mSeq[i] < mSeq[sel]) sel = i;
`else
                    if (sel < 0) sel = i;
`endif
                end
            end
            if (sel >= 0) begin
                mIv = 1'b1;
                mIOp = mOp[sel]; mIPc = mPc[sel];
                mISrc1 = wd1[sel]; mISrc2 = wd2[sel]; mIDest = mDest[sel];
                mBusy[sel] = 1'b0;
                mCnt--;
            end else begin
                mIv = 1'b0;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            mT1[i] = wt1[i]; mD1[i] = wd1[i];
            mT2[i] = wt2[i]; mD2[i] = wd2[i];
        end
        if (ai >= 0) begin
            mBusy[ai] = 1'b1;
            mOp[ai] = alloc_op; mPc[ai] = alloc_pc; mDest[ai] = alloc_dest;
            mT1[ai] = alloc_src1_tag; mD1[ai] = alloc_src1_data;
            mT2[ai] = alloc_src2_tag; mD2[ai] = alloc_src2_data;
            if (cdbHit(alloc_src1_tag, d)) begin mT1[ai] = 4'd0; mD1[ai] = d; end
            if (cdbHit(alloc_src2_tag, d)) begin mT2[ai] = 4'd0; mD2[ai] = d; end
            mSeq[ai] = nextSeq++;
            mCnt++;
        end
    endtask

    always @(posedge rst) modelReset();

    // Compare process: step the model at each edge, check the DUT just after it.
    always @(posedge clk) begin
        modelStep();
        #1;
        checkOutput("count", 64'(count), 64'(mCnt));
        checkOutput("alloc_ready", 64'(alloc_ready), 64'(mCnt < DEPTH));
        checkOutput("issue_valid", 64'(issue_valid), 64'(mIv));
        if (mIv) begin
            checkOutput("issue_op", 64'(issue_op), 64'(mIOp));
            checkOutput("issue_pc", 64'(issue_pc), 64'(mIPc));
            checkOutput("issue_src1", 64'(issue_src1), 64'(mISrc1));
            checkOutput("issue_src2", 64'(issue_src2), 64'(mISrc2));
            checkOutput("issue_dest", 64'(issue_dest), 64'(mIDest));
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit av, input logic [5:0] op, input logic [3:0] t1,
                                 input logic [31:0] d1, input logic [3:0] t2,
                                 input logic [31:0] d2, input logic [3:0] dest);
        alloc_valid = av;
        alloc_op = op;
        alloc_pc = 32'h1000 + 32'(dest);
        alloc_src1_tag = t1; alloc_src1_data = d1;
        alloc_src2_tag = t2; alloc_src2_data = d2;
        alloc_dest = dest;
    endtask

    task automatic setCdb(input int ch, input bit v, input logic [3:0] t, input logic [31:0] d);
        cdb_valid[ch] = v;
        cdb_tag[ch*TW +: TW] = t;
        cdb_data[ch*DW +: DW] = d;
    endtask

    task automatic doFlush();
        alloc_valid = 1'b0;
        cdb_valid = '0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [3:0] expOrder [3];
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; issue_ready = 1'b1;
        cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        cycle(); cycle();
        checkOutput("reset count", 64'(count), 64'd0);
        checkOutput("reset issue_dest", 64'(issue_dest), 64'd0);
        rst = 1'b0;
        cycle();

        // Free operands issue one edge after allocation.
        doFlush();
        applyStimulus(1, 6'h01, 4'd0, 32'd5, 4'd0, 32'd7, 4'd3);
        cycle();
        checkOutput("t2 count after alloc", 64'(count), 64'd1);
        checkOutput("t2 valid after alloc", 64'(issue_valid), 64'd0);
        alloc_valid = 1'b0;
        cycle();
        checkOutput("t2 valid", 64'(issue_valid), 64'd1);
        checkOutput("t2 src1", 64'(issue_src1), 64'd5);
        checkOutput("t2 src2", 64'(issue_src2), 64'd7);
        checkOutput("t2 dest", 64'(issue_dest), 64'd3);
        checkOutput("t2 count", 64'(count), 64'd0);

        // Lower CDB channel wins, and an op issues in its wakeup cycle.
        doFlush();
        applyStimulus(1, 6'h02, 4'd2, 32'd0, 4'd0, 32'd1, 4'd5);
        cycle();
        alloc_valid = 1'b0;
        setCdb(1, 1, 4'd2, 32'hAA);
        setCdb(0, 1, 4'd2, 32'h55);
        cycle();
        checkOutput("t3 wake valid", 64'(issue_valid), 64'd1);
        checkOutput("t3 cdb priority", 64'(issue_src1), 64'h55);
        cdb_valid = '0;
        cycle();
        // Broadcast in the allocation cycle is captured.
        applyStimulus(1, 6'h03, 4'd2, 32'd0, 4'd0, 32'd2, 4'd6);
        setCdb(0, 1, 4'd2, 32'h77);
        cycle();
        checkOutput("t3 capture not yet", 64'(issue_valid), 64'd0);
        alloc_valid = 1'b0;
        cdb_valid = '0;
        cycle();
        checkOutput("t3 capture valid", 64'(issue_valid), 64'd1);
        checkOutput("t3 capture src1", 64'(issue_src1), 64'h77);

        // Fill to DEPTH, then drain at one issue per cycle.
        doFlush();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1, 6'(i), 4'd9, 32'd0, 4'd0, 32'(i), 4'(i + 1));
            cycle();
        end
        checkOutput("t4 full count", 64'(count), 64'd8);
        checkOutput("t4 full ready", 64'(alloc_ready), 64'd0);
        applyStimulus(1, 6'h3F, 4'd0, 32'd1, 4'd0, 32'd1, 4'd15);
        cycle();
        checkOutput("t4 ignored alloc", 64'(count), 64'd8);
        alloc_valid = 1'b0;
        setCdb(0, 1, 4'd9, 32'h99);
        cycle();
        cdb_valid = '0;
        checkOutput("t4 first issue count", 64'(count), 64'd7);
        checkOutput("t4 first issue src1", 64'(issue_src1), 64'h99);
        for (int i = 6; i >= 0; i--) begin
            cycle();
            checkOutput("t4 drain count", 64'(count), 64'(i));
        end

        // Backpressure holds the output register while entries wake.
        doFlush();
        issue_ready = 1'b0;
        applyStimulus(1, 6'h04, 4'd0, 32'd1, 4'd5, 32'd0, 4'd2);
        cycle();
        applyStimulus(1, 6'h05, 4'd0, 32'd2, 4'd5, 32'd0, 4'd3);
        cycle();
        applyStimulus(1, 6'h06, 4'd0, 32'd3, 4'd0, 32'd4, 4'd1);
        cycle();
        alloc_valid = 1'b0;
        cycle();
        checkOutput("t5 loaded dest", 64'(issue_dest), 64'd1);
        setCdb(0, 1, 4'd5, 32'h5A5A);
        for (int i = 0; i < 4; i++) begin
            cycle();
            cdb_valid = '0;
            checkOutput("t5 held dest", 64'(issue_dest), 64'd1);
            checkOutput("t5 held src1", 64'(issue_src1), 64'd3);
            checkOutput("t5 held count", 64'(count), 64'd2);
        end
        issue_ready = 1'b1;
        cycle();
        checkOutput("t5 next dest", 64'(issue_dest), 64'd2);
        checkOutput("t5 next src2", 64'(issue_src2), 64'h5A5A);
        checkOutput("t5 next count", 64'(count), 64'd1);

        // Flush with entries busy overrides a simultaneous allocation.
        doFlush();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 6'h07, 4'd7, 32'd0, 4'd0, 32'd0, 4'(i + 1));
            cycle();
        end
        checkOutput("t6 pre-flush count", 64'(count), 64'd5);
        applyStimulus(1, 6'h08, 4'd0, 32'd1, 4'd0, 32'd1, 4'd9);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        alloc_valid = 1'b0;
        checkOutput("t6 flush count", 64'(count), 64'd0);
        checkOutput("t6 flush valid", 64'(issue_valid), 64'd0);
        cycle();
        checkOutput("t6 alloc dropped", 64'(count), 64'd0);

        // Entries 4, 0, 2 allocated in that order, then woken together.
        applyStimulus(1, 6'h09, 4'd10, 32'd0, 4'd0, 32'd0, 4'd1); cycle();
        applyStimulus(1, 6'h09, 4'd11, 32'd0, 4'd0, 32'd0, 4'd2); cycle();
        applyStimulus(1, 6'h09, 4'd10, 32'd0, 4'd0, 32'd0, 4'd3); cycle();
        applyStimulus(1, 6'h09, 4'd11, 32'd0, 4'd0, 32'd0, 4'd4); cycle();
        applyStimulus(1, 6'h0A, 4'd12, 32'd0, 4'd0, 32'd0, 4'd13); cycle();
        alloc_valid = 1'b0;
        setCdb(0, 1, 4'd10, 32'h10);
        cycle();
        cdb_valid = '0;
        cycle(); cycle();
        applyStimulus(1, 6'h0B, 4'd12, 32'd0, 4'd0, 32'd0, 4'd14); cycle();
        applyStimulus(1, 6'h0C, 4'd12, 32'd0, 4'd0, 32'd0, 4'd15); cycle();
        alloc_valid = 1'b0;
        setCdb(1, 1, 4'd12, 32'h12);
`ifdef RS_OLDEST_FIRST_EN
        expOrder[0] = 4'd13; expOrder[1] = 4'd14; expOrder[2] = 4'd15;
`else
        expOrder[0] = 4'd14; expOrder[1] = 4'd15; expOrder[2] = 4'd13;
`endif
        for (int i = 0; i < 3; i++) begin
            cycle();
            cdb_valid = '0;
            checkOutput("t6 issue order", 64'(issue_dest), 64'(expOrder[i]));
        end
        setCdb(0, 1, 4'd11, 32'h11);
        cycle();
        cdb_valid = '0;
        cycle(); cycle();

        // Asynchronous reset mid-run with three entries busy.
        doFlush();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 6'h0D, 4'd4, 32'd0, 4'd0, 32'd0, 4'(i + 7));
            cycle();
        end
        alloc_valid = 1'b0;
        checkOutput("t1 pre-reset count", 64'(count), 64'd3);
        rst = 1'b1;
        #1;
        checkOutput("t1 rst count", 64'(count), 64'd0);
        checkOutput("t1 rst valid", 64'(issue_valid), 64'd0);
        checkOutput("t1 rst alloc_ready", 64'(alloc_ready), 64'd1);
        checkOutput("t1 rst dest", 64'(issue_dest), 64'd0);
        cycle();
        rst = 1'b0;
        cycle();

        // Randomized traffic checked by the model.
        for (int n = 0; n < 3000; n++) begin
            rdy = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 59) == 0);
            issue_ready = ($urandom_range(0, 9) < 7);
            applyStimulus($urandom_range(0, 1) == 1, 6'($urandom), 4'($urandom_range(0, 3)),
                          $urandom, 4'($urandom_range(0, 3)), $urandom, 4'($urandom));
            for (int c = 0; c < NC; c++) begin
                setCdb(c, $urandom_range(0, 2) == 0, 4'($urandom_range(1, 3)), $urandom);
            end
            cycle();
        end
        rdy = 1'b1; flush = 1'b0; alloc_valid = 1'b0; cdb_valid = '0;
        cycle(); cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rs_alu_param.md
Name: rs_alu_param

Overview:
Parametrised ALU reservation station, successor to the fixed-size ALU RS. Sits between decoder/rename and the ALU execute stage.
- Holds up to DEPTH renamed ALU ops and snoops NUM_CDB result buses to wake up operands.
- Issues one ready op per cycle through a registered valid/ready output with backpressure.
- Supports a pipeline flush and reports an occupancy count for front-end stall.

Parameters:
DEPTH, 8, number of entries (>=2)
DATA_W, 32, operand/result width
TAG_W, 4, ROB/rename tag width
TAG_FREE, 0, tag value meaning "operand valid / no producer"
NUM_CDB, 2, number of result broadcast channels; lower index has priority
OP_W, 6, ALU opcode width
PC_W, 32, instruction PC width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rdy  in  1  global enable; low = all state held
flush  in  1  synchronous squash of all entries and the output register
alloc_valid  in  1  decoder presents an op
alloc_ready  out  1  RS can accept (count < DEPTH)
alloc_op  in  OP_W  opcode
alloc_pc  in  PC_W  instruction PC
alloc_src1_data / alloc_src2_data  in  DATA_W  operand values
alloc_src1_tag / alloc_src2_tag  in  TAG_W  producer tags (TAG_FREE = value valid)
alloc_dest  in  TAG_W  destination tag
cdb_valid  in  NUM_CDB  per-channel broadcast valid
cdb_tag  in  NUM_CDB*TAG_W  packed tags, channel i at [i*TAG_W +: TAG_W]
cdb_data  in  NUM_CDB*DATA_W  packed data
issue_valid  out  1  output register holds an op
issue_ready  in  1  ALU accepts the op
issue_op / issue_pc / issue_src1 / issue_src2 / issue_dest  out  OP_W/PC_W/DATA_W/DATA_W/TAG_W  issued op fields
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset: all busy=0, count=0, issue_valid=0, issue_op/pc/src1/src2=0, issue_dest=TAG_FREE; hence alloc_ready=1.
- rdy=0: no allocation, wakeup, issue or flush. Registers hold. Outputs are stable.
- alloc_ready = (count < DEPTH), derived from registered count only; no same-cycle issue look-ahead.
- Allocate fires when rdy && alloc_valid && alloc_ready && !flush. It writes the lowest-index non-busy entry.
- Allocation-cycle capture: each incoming source tag (!=TAG_FREE) is compared to the current CDB. On a match, the entry stores the CDB data and TAG_FREE, so no broadcast is missed.
- Wakeup: every busy entry compares each pending tag against all valid CDB channels. On a match it stores the data and sets the tag to TAG_FREE. If several channels match, the lowest channel index wins.
- Entry ready (comb) = busy && both next-tags == TAG_FREE. next-tag includes the current-cycle CDB match, so an op can issue in its wakeup cycle with forwarded data.
- Output register load condition: load = !issue_valid || issue_ready.
  - load && any ready entry: selected entry's forwarded fields go to the issue_* registers; issue_valid<=1; busy cleared.
  - load && none ready: issue_valid<=0.
  - !load: issue_* held bit-stable; no entry is freed.
- A newly allocated entry is not ready in its allocation cycle. Minimum latency is alloc edge N -> issue_valid high after edge N+1.
- count_next = count + alloc_fire - issue_fire; simultaneous alloc and issue leaves count unchanged.
- Full: count==DEPTH -> alloc_ready=0 and alloc_valid is ignored. Empty: no issue; issue_valid drops after the held op is accepted.
- flush (with rdy): busy<=0, count<=0, issue_valid<=0 at that edge. It overrides allocate, wakeup and issue in the same cycle. The issue_* data registers may keep stale values.
- Async rst mid-operation returns immediately to reset values; in-flight ops are lost.

Optional Feature:
RS_OLDEST_FIRST_EN
- Defined: a DEPTH x DEPTH age matrix is updated on allocate (new entry younger than all busy entries) and cleared on free/flush. Issue selects the oldest ready entry.
- Undefined: issue selects the lowest-index ready entry (fixed priority); no age state exists.
- Identical in both builds: port list, latency and all other behaviour.

Test Plan:
1. Assert rst mid-run with 3 entries busy -> immediately count=0, issue_valid=0, alloc_ready=1, issue_dest=TAG_FREE.
2. Alloc op=ADD, src1=5, src2=7 (tags TAG_FREE), dest=3; issue_ready=1 -> issue_valid=1 with src1=5, src2=7, dest=3 one edge after the allocation edge; count returns 1->0.
3. Alloc src1_tag=2, then drive cdb_valid[1]=1, tag=2, data=0xAA and simultaneously cdb_valid[0]=1, tag=2, data=0x55 -> issued src1=0x55 (channel 0 priority) at that same edge. Separately, CDB tag 2 in the allocation cycle itself -> src1 captured, op issues next edge.
4. Allocate 8 ops with src1_tag=9 pending -> count=8, alloc_ready=0, 9th alloc_valid ignored. Broadcast tag 9 with issue_ready=1 -> one issue per cycle, count 8->0.
5. issue_valid=1, issue_ready=0 for 4 cycles while CDB wakes other entries -> issue_* unchanged and count unchanged. Raise issue_ready -> next op issued at that edge.
6. Flush with 5 entries busy plus a simultaneous alloc_valid -> count=0, issue_valid=0, allocation dropped. With RS_OLDEST_FIRST_EN, alloc into entries 4, 0, 2 then wake all -> issue order 4, 0, 2; without the macro -> 0, 2, 4.
